instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 in_valid  input  1  request carries a field set to encode.
REQ-004 in_ready  output  1  encoder can accept a request this cycle.
REQ-005 in_fmt  input  3  format: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J; 110/111 invalid.
REQ-006 in_opcode  input  7  opcode field.
REQ-007 in_rd / in_rs1 / in_rs2  input  5 each  register addresses.
REQ-008 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-009 in_imm  input  32  immediate as a signed byte offset or value, not pre-scrambled.
REQ-010 out_valid  output  1  out_instr is valid.
REQ-011 out_ready  input  1  consumer takes the word when out_valid && out_ready.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_error  output  1  word flagged as range or format error.
REQ-014 encoded_count  output  16  words delivered, wraps.
REQ-015 error_count  output  8  error words delivered, saturates at 255.

Function
REQ-016 Accept when in_valid && in_ready; packed word enters a 2-entry FIFO; word is at head and out_valid=1 the cycle after the accept if the FIFO was empty (latency 1).
REQ-017 in_ready = (occupancy != 2), combinational from occupancy only, never from out_ready.
REQ-018 Pop when out_valid && out_ready; simultaneous push and pop leaves occupancy unchanged; full throughput of 1 word/cycle sustained at occupancy 1.
REQ-019 Order preserved; out_instr and out_error stable while out_valid && !out_ready.
REQ-020 Common fields: [6:0]=opcode; rd [11:7] for R/I/U/J; funct3 [14:12] and rs1 [19:15] for R/I/S/B; rs2 [24:20] for R/S/B; funct7 [31:25] for R.
REQ-021 I: [31:20]=imm[11:0]; range error unless imm[31:11] all equal.
REQ-022 I shift (opcode 0010011, funct3 001/101): [31:25]=funct7, [24:20]=imm[4:0]; error unless imm[31:5]==0.
REQ-023 S: [31:25]=imm[11:5], [11:7]=imm[4:0]; same range rule as I.
REQ-024 B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; error unless imm[31:12] all equal and imm[0]==0.
REQ-025 U: [31:12]=imm[31:12]; error unless imm[11:0]==0.
REQ-026 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; error unless imm[31:20] all equal and imm[0]==0.
REQ-027 Range error: word still emitted with truncated fields, out_error=1.
REQ-028 Invalid fmt: out_instr=0x00000013 (NOP), out_error=1.
REQ-029 encoded_count +1 per pop, wraps 0xFFFF->0x0000; error_count +1 per pop with out_error=1, holds at 255.

Reset
REQ-030 rst sampled on clk edge: occupancy 0, out_valid=0, out_instr=0, out_error=0, encoded_count=0, error_count=0; in_ready=1 the cycle after.
REQ-031 rst mid-operation discards buffered words; a handshake coincident with rst is not counted and not stored.
REQ-032 No request is accepted while rst=1 (in_ready=0 during rst).

Verification
REQ-033 ADDI fmt I, opcode 0010011, rd 1, rs1 0, funct3 0, imm 5 -> out_instr 0x00500093 one cycle later, out_error 0.
REQ-034 BEQ fmt B, opcode 1100011, rs1 0, rs2 0, funct3 0, imm -4 -> 0xFE000EE3; JAL fmt J, opcode 1101111, rd 1, imm 8 -> 0x008000EF.
REQ-035 LUI fmt U, opcode 0110111, rd 5, imm 0x12345000 -> 0x123452B7; same with imm 0x12345001 -> 0x123452B7, out_error 1, error_count 1.
REQ-036 out_ready=0, 3 back-to-back requests -> in_ready drops after 2nd accept, 3rd held; raise out_ready -> 3 words in order on consecutive cycles, encoded_count 3.
REQ-037 fmt 111 -> 0x00000013, out_error 1; I imm 2048 -> out_error 1; 300 error words -> error_count 255.
REQ-038 Assert rst with 2 words buffered -> next cycle out_valid 0, counters 0, in_ready 1.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder.
// master: producer of field sets and consumer of encoded words.
// slave: the encoder itself.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_error;
  logic [15:0] encoded_count;
  logic [7:0]  error_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_error,
           encoded_count, error_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_error,
           encoded_count, error_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V style field sets into 32-bit words, flagging range/format errors.
// Latency 1 cycle from accept to out_valid through a 2-entry output FIFO.
// in_ready depends on FIFO occupancy only; words hold at the head until out_ready.
module instr_encoder (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } word_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  word_t       enc_word;
  word_t       mem_q [2];
  word_t       mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic [15:0] enc_cnt_q, enc_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        push;
  logic        pop;
  logic        i_rng_ok;
  logic        b_rng_ok;
  logic        j_rng_ok;
  logic        is_shift;
  logic [31:0] imm;
  word_t       head;

  assign imm      = bus.in_imm;
  assign i_rng_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_rng_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign j_rng_ok = (&imm[31:20]) | ~(|imm[31:20]);
  assign is_shift = (bus.in_opcode == 7'b0010011) &&
                    ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

  // Combinational field packing and error detection for the incoming request.
  always_comb begin
    enc_word = '0;
    case (bus.in_fmt)
      3'b000: begin
        enc_word.instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
        enc_word.err   = 1'b0;
      end
      3'b001: begin
        if (is_shift) begin
          enc_word.instr = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
          enc_word.err   = |imm[31:5];
        end else begin
          enc_word.instr = {imm[11:0], bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
          enc_word.err   = ~i_rng_ok;
        end
      end
      3'b010: begin
        enc_word.instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          imm[4:0], bus.in_opcode};
        enc_word.err   = ~i_rng_ok;
      end
      3'b011: begin
        enc_word.instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          imm[4:1], imm[11], bus.in_opcode};
        enc_word.err   = ~b_rng_ok | imm[0];
      end
      3'b100: begin
        enc_word.instr = {imm[31:12], bus.in_rd, bus.in_opcode};
        enc_word.err   = |imm[11:0];
      end
      3'b101: begin
        enc_word.instr = {imm[20], imm[10:1], imm[11], imm[19:12],
                          bus.in_rd, bus.in_opcode};
        enc_word.err   = ~j_rng_ok | imm[0];
      end
      default: begin
        // Unknown format: emit a harmless NOP so downstream never sees garbage.
        enc_word.instr = NOP_WORD;
        enc_word.err   = 1'b1;
      end
    endcase
  end

  // Handshakes: ready is blocked during reset so a coincident request is never taken.
  assign bus.in_ready  = (occ_q != 2'd2) && !rst;
  assign bus.out_valid = (occ_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign head          = mem_q[rd_ptr_q];

  assign bus.out_instr     = bus.out_valid ? head.instr : 32'h0;
  assign bus.out_error     = bus.out_valid ? head.err   : 1'b0;
  assign bus.encoded_count = enc_cnt_q;
  assign bus.error_count   = err_cnt_q;

  // Next-state for FIFO storage, pointers, occupancy and delivery counters.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      enc_cnt_d = enc_cnt_q + 16'd1;
      if (head.err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset discards buffered words and clears the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      enc_cnt_q <= 16'd0;
      err_cnt_q <= 8'd0;
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with a queue-based scoreboard.
// Driver pushes the hand-computed word when its request is accepted;
// a negedge monitor pops and compares on every output handshake.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [32:0] sb [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare head against scoreboard on pops, and check it holds while stalled.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %h expected none at %0t", bus.out_instr, $time);
      end else if (bus.out_ready) begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("out_instr", bus.out_instr, e[31:0]);
        chk("out_error", {31'd0, bus.out_error}, {31'd0, e[32]});
      end else begin
        chk("hold_instr", bus.out_instr, sb[0][31:0]);
      end
    end
  end

  // Entered and left at posedge+1; in_valid stays high on return for back-to-back use.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    int cnt;
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back({exp_err, exp_instr});
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (cnt > 200) begin
        n_total++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
        break;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Waits until the scoreboard empties, then lands at posedge+1 after the last pop.
  task automatic drain();
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_opcode = 7'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_imm    = 32'd0;
    bus.out_ready = 1'b1;

    // Reset behaviour.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_enc_cnt", {16'd0, bus.encoded_count}, 32'd0);
    chk("rst_err_cnt", {24'd0, bus.error_count}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic encodings; ADDI also checks single-cycle latency.
    send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    chk("addi_latency", {31'd0, bus.out_valid}, 32'd1);
    send(3'b011, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    send(3'b101, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    idle();
    drain();
    chk("enc_cnt_5", {16'd0, bus.encoded_count}, 32'd5);
    chk("err_cnt_1", {24'd0, bus.error_count}, 32'd1);

    // Backpressure: two fill the FIFO, the third waits until the consumer resumes.
    bus.out_ready = 1'b0;
    send(3'b000, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    send(3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    fork
      begin
        send(3'b001, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'd3,
             32'h4033_5293, 1'b0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("burst_enc_cnt", {16'd0, bus.encoded_count}, 32'd8);
        chk("burst_empty", {31'd0, bus.out_valid}, 32'd0);
      end
    join

    // Error and boundary cases.
    send(3'b111, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    send(3'b110, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1);
    send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1, 32'hFFF0_0093, 1'b0);
    send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2049, 32'h7FF0_0093, 1'b1);
    send(3'b011, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1);
    send(3'b001, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'd32,
         32'h4003_5293, 1'b1);
    send(3'b101, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2, 32'hFFFF_F0EF, 1'b0);
    idle();
    drain();
    chk("enc_cnt_16", {16'd0, bus.encoded_count}, 32'd16);
    chk("err_cnt_7", {24'd0, bus.error_count}, 32'd7);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send(3'b111, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    end
    idle();
    drain();
    chk("err_cnt_sat", {24'd0, bus.error_count}, 32'd255);
    chk("enc_cnt_316", {16'd0, bus.encoded_count}, 32'd316);

    // Reset with two words buffered and a request presented during reset.
    bus.out_ready = 1'b0;
    send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    send(3'b101, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_blocks_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_enc_cnt", {16'd0, bus.encoded_count}, 32'd0);
    chk("flush_err_cnt", {24'd0, bus.error_count}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(3'b000, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'd0, 32'h4020_81B3, 1'b0);
    idle();
    drain();
    chk("post_rst_enc_cnt", {16'd0, bus.encoded_count}, 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
